// File: rtl/dut_cmd_proc.sv
// Purpose : command processor - decodes one 16-bit command per clock into accumulator, LIFO and sticky-flag updates.
// Latency : 1 cycle; dout is registered and reflects the command sampled at the same posedge.
// Backpressure: none; every cycle carries a command (NOP for idle), so the block always accepts.
//
// Ports:
//   clk   - sole clock, all state updates on posedge
//   rst_n - asynchronous active-low reset
//   din   - command word: [15:12] opcode, [11:0] operand
//   dout  - registered accumulator, or the status word for the cycle after a STAT
module dut_cmd_proc #(
    parameter int STACK_DEPTH = 4,
    parameter int DW          = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [7:0] DEPTH_MAX = 8'(STACK_DEPTH);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_PUSH = 4'd4,
        OP_POP  = 4'd5,
        OP_CLR  = 4'd6,
        OP_STAT = 4'd7,
        OP_CLRF = 4'd8
    } opcode_t;

    // Architectural state
    logic [DW-1:0] acc_q;
    logic [7:0]    depth_q;
    logic [DW-1:0] stack_q [STACK_DEPTH];
    logic          ovf_q, unf_q, carry_q, borrow_q, ill_q;

    // Next-state values
    logic [DW-1:0] acc_d;
    logic [7:0]    depth_d;
    logic          ovf_d, unf_d, carry_d, borrow_d, ill_d;
    logic          push_en;
    logic [DW-1:0] dout_d;

    logic [3:0]    opcode;
    logic [DW-1:0] opr;
    logic [DW:0]   sum;
    logic [7:0]    depth_m1;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] top_idx;
    logic [DW-1:0] status_word;

    assign opcode   = din[15:12];
    assign opr      = {4'b0000, din[11:0]};
    assign sum      = {1'b0, acc_q} + {1'b0, opr};
    assign depth_m1 = depth_q - 8'd1;
    assign push_idx = depth_q[AW-1:0];
    assign top_idx  = depth_m1[AW-1:0];

    // Status reflects flags/depth held before the current command takes effect.
    assign status_word = {ovf_q, unf_q, carry_q, borrow_q, ill_q, 3'b000, depth_q};

    always_comb begin
        acc_d    = acc_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ill_d    = ill_q;
        push_en  = 1'b0;

        case (opcode)
            OP_NOP:  ;
            OP_LOAD: acc_d = opr;
            OP_ADD: begin
                acc_d = sum[DW-1:0];
                if (sum[DW]) carry_d = 1'b1;
            end
            OP_SUB: begin
                acc_d = acc_q - opr;
                if (opr > acc_q) borrow_d = 1'b1;
            end
            OP_PUSH: begin
                if (depth_q < DEPTH_MAX) begin
                    push_en = 1'b1;
                    depth_d = depth_q + 8'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OP_POP: begin
                if (depth_q != 8'd0) begin
                    acc_d   = stack_q[top_idx];
                    depth_d = depth_m1;
                end else begin
                    unf_d = 1'b1;
                end
            end
            OP_CLR:  acc_d = '0;
            OP_STAT: ;
            OP_CLRF: begin
                ovf_d    = 1'b0;
                unf_d    = 1'b0;
                carry_d  = 1'b0;
                borrow_d = 1'b0;
                ill_d    = 1'b0;
            end
            default: ill_d = 1'b1;
        endcase

        dout_d = (opcode == OP_STAT) ? status_word : acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ill_q    <= 1'b0;
            dout     <= '0;
        end else begin
            acc_q    <= acc_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ill_q    <= ill_d;
            dout     <= dout_d;
        end
    end

    // Stack storage is not reset: entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            stack_q[push_idx] <= acc_q;
        end
    end

endmodule

// File: tb/tb_dut_cmd_proc.sv
module tb_dut_cmd_proc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic [15:0] dout;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int m_acc;
    int m_stk[$];
    bit m_ovf, m_unf, m_carry, m_borrow, m_ill;

    localparam int DEPTH = 4;

    dut_cmd_proc #(.STACK_DEPTH(DEPTH), .DW(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = 0;
        m_stk.delete();
        m_ovf = 0; m_unf = 0; m_carry = 0; m_borrow = 0; m_ill = 0;
    endtask

    // Applies one command to the model and returns the expected dout.
    function automatic logic [15:0] model(input logic [15:0] cmd);
        int op, opr;
        logic [15:0] st;
        op  = int'(cmd[15:12]);
        opr = int'(cmd[11:0]);
        st  = {m_ovf, m_unf, m_carry, m_borrow, m_ill, 3'b000, 8'(m_stk.size())};
        case (op)
            0: ;
            1: m_acc = opr;
            2: begin
                if (m_acc + opr > 65535) m_carry = 1;
                m_acc = (m_acc + opr) % 65536;
            end
            3: begin
                if (opr > m_acc) m_borrow = 1;
                m_acc = (m_acc - opr + 65536) % 65536;
            end
            4: if (m_stk.size() < DEPTH) m_stk.push_back(m_acc); else m_ovf = 1;
            5: if (m_stk.size() > 0) m_acc = m_stk.pop_back(); else m_unf = 1;
            6: m_acc = 0;
            7: return st;
            8: begin m_ovf = 0; m_unf = 0; m_carry = 0; m_borrow = 0; m_ill = 0; end
            default: m_ill = 1;
        endcase
        return 16'(m_acc);
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (dout === exp) else begin
            fails++;
            $error("FAIL %s: dout=%h expected %h", tag, dout, exp);
        end
    endtask

    task automatic step(input logic [15:0] cmd, input string tag);
        logic [15:0] e;
        @(negedge clk);
        din = cmd;
        e = model(cmd);
        @(posedge clk);
        #1;
        check(tag, e);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 16'h0000;
        model_reset();
        #12;
        check("reset_dout", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 3; i++) step(16'h0000, "nop_idle");
        step(16'h7000, "stat_clean");

        // Load / add
        step(16'h1123, "load_123");
        step(16'h20FF, "add_0ff");
        step(16'h7000, "stat_no_flags");

        // Carry and borrow
        step(16'h1FFF, "load_fff");
        for (int i = 0; i < 16; i++) step(16'h2FFF, "add_fff_chain");
        step(16'h1001, "load_001");
        step(16'h3002, "sub_borrow");
        step(16'h7000, "stat_carry_borrow");
        step(16'h8000, "clrf");
        step(16'h7000, "stat_after_clrf");

        // LIFO ordering, overflow, underflow
        for (int i = 1; i <= 5; i++) begin
            step(16'h1000 | 16'(i), "load_n");
            step(16'h4000, "push_n");
        end
        step(16'h7000, "stat_ovf_full");
        for (int i = 0; i < 4; i++) step(16'h5000, "pop_order");
        step(16'h5000, "pop_empty");
        step(16'h7000, "stat_ovf_unf");
        step(16'h0000, "nop_after_stat");

        // Illegal opcode from clean flags
        step(16'h8000, "clrf2");
        step(16'h1055, "load_055");
        step(16'hF000, "illegal_f");
        step(16'h7000, "stat_ill");
        step(16'h8000, "clrf3");
        step(16'h7000, "stat_clrf_no_ill");

        // Reset mid-sequence
        step(16'h1ABC, "load_abc");
        step(16'h4000, "push_abc");
        @(negedge clk);
        rst_n = 1'b0;
        din   = 16'h1555;
        #1;
        check("async_reset", 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        check("held_reset", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        din   = 16'h0000;
        step(16'h7000, "stat_post_reset");
        step(16'h5000, "pop_post_reset");
        step(16'h7000, "stat_unf_post_reset");

        // Randomized commands against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] cmd;
            int r;
            r = int'($urandom_range(0, 19));
            cmd[11:0] = 12'($urandom);
            if (r < 16) cmd[15:12] = 4'(r);
            else if (r < 18) cmd[15:12] = 4'd4;
            else cmd[15:12] = 4'd5;
            step(cmd, "random");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
